// File: rtl/pipe_hazard_ctrl_if.sv
// Purpose : hazard-information and pipeline-control bundle between the
//           5-stage datapath and the central stall/flush sequencer.
// Ports   : master = datapath side (drives hazard info, dmem_ack; receives
//           enables/flushes/strobe/status), slave = hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // hazard information from the datapath
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             branch_taken_ex;
  logic             mem_req;
  logic             dmem_ack;
  // pipeline-register controls back to the datapath
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic             ex_mem_en;
  logic             mem_wb_bubble;
  logic             dmem_start;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rd, branch_taken_ex,
           mem_req, dmem_ack,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_bubble, dmem_start, mem_timeout_err, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rd, branch_taken_ex,
           mem_req, dmem_ack,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_bubble, dmem_start, mem_timeout_err, stall_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Purpose : stall/flush sequencer for the 5-stage pipeline; priority is
//           data-memory freeze > taken-branch flush > load-use stall.
// Latency : all pipeline controls are combinational from state and inputs;
//           only FSM state, wait counter, error flag and stall counter are flops.
// Backpressure: an unfinished data-memory access freezes every pipeline
//           register (MEM/WB takes a bubble) until dmem_ack, or for good
//           once the wait exceeds MEM_TIMEOUT.
// Ports   : clk, reset (async, active-low), bus (pipe_hazard_ctrl_if.slave).
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic freeze;
  logic load_use;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en;
  logic mem_wb_bubble, dmem_start;

  // r0 is hardwired to zero, so a load "into" r0 never creates a dependency
  assign load_use = bus.ex_memread && (bus.ex_rd != 5'd0) &&
                    ((bus.ex_rd == bus.id_rs) ||
                     (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));

  // next state / wait counting
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    freeze     = 1'b0;
    dmem_start = 1'b0;
    case (state_q)
      RUN: begin
        // start is issued even for a zero-wait access (ack in the same cycle)
        dmem_start = bus.mem_req;
        if (bus.mem_req && !bus.dmem_ack) begin
          freeze     = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ack) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else begin
          freeze = 1'b1;
          if (wait_cnt_q == TIMEOUT_C) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      ERROR: begin
        // terminal: only reset leaves, a late ack is ignored
        freeze = 1'b1;
        err_d  = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // pipeline-register controls in priority order
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_bubble = 1'b0;
    if (freeze) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (bus.branch_taken_ex) begin
      // the dependent load-use instruction is on the wrong path anyway
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_en && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= 8'd0;
      err_q         <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      err_q         <= err_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.pc_en           = pc_en;
  assign bus.if_id_en        = if_id_en;
  assign bus.if_id_flush     = if_id_flush;
  assign bus.id_ex_en        = id_ex_en;
  assign bus.id_ex_flush     = id_ex_flush;
  assign bus.ex_mem_en       = ex_mem_en;
  assign bus.mem_wb_bubble   = mem_wb_bubble;
  assign bus.dmem_start      = dmem_start;
  assign bus.mem_timeout_err = err_q;
  assign bus.stall_count     = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench: the driver applies one vector per cycle and pushes
// the hand-computed expectation; the monitor pops and compares mid-cycle.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 16;

  // control word order: pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
  // ex_mem_en, mem_wb_bubble, dmem_start
  localparam logic [7:0] C_NORM   = 8'b1101_0100;
  localparam logic [7:0] C_ZW     = 8'b1101_0101;
  localparam logic [7:0] C_BR     = 8'b1111_1100;
  localparam logic [7:0] C_LU     = 8'b0001_1100;
  localparam logic [7:0] C_FRZ    = 8'b0000_0010;
  localparam logic [7:0] C_FRZ_ST = 8'b0000_0011;

  typedef struct {
    logic             rst_n;
    logic [4:0]       rs, rt, rd;
    logic             uses_rt, memread, br, mreq, ack;
    logic [7:0]       exp_ctrl;
    logic             exp_err;
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t vec_q[$];
  vec_t exp_q[$];

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic rst_n, input logic [4:0] rs, input logic [4:0] rt,
                     input logic uses_rt, input logic memread, input logic [4:0] rd,
                     input logic br, input logic mreq, input logic ack,
                     input logic [7:0] ctrl, input logic err, input int cnt);
    vec_t v;
    v.rst_n = rst_n; v.rs = rs; v.rt = rt; v.uses_rt = uses_rt;
    v.memread = memread; v.rd = rd; v.br = br; v.mreq = mreq; v.ack = ack;
    v.exp_ctrl = ctrl; v.exp_err = err; v.exp_cnt = CNT_W'(cnt);
    vec_q.push_back(v);
  endtask

  task automatic idle(input logic rst_n, input logic [7:0] ctrl, input logic err,
                      input int cnt);
    add(rst_n, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ctrl, err, cnt);
  endtask

  task automatic mem(input logic br, input logic mreq, input logic ack,
                     input logic [7:0] ctrl, input logic err, input int cnt);
    add(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, br, mreq, ack, ctrl, err, cnt);
  endtask

  task automatic check(input string name, input int idx, input longint act,
                       input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // monitor: outputs are valid every cycle, sampled on the falling edge
  int mon_idx = 0;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t e;
      logic [7:0] act_ctrl;
      e = exp_q.pop_front();
      act_ctrl = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en,
                  bus.id_ex_flush, bus.ex_mem_en, bus.mem_wb_bubble, bus.dmem_start};
      check("ctrl", mon_idx, longint'(act_ctrl), longint'(e.exp_ctrl));
      check("timeout_err", mon_idx, longint'(bus.mem_timeout_err), longint'(e.exp_err));
      check("stall_count", mon_idx, longint'(bus.stall_count), longint'(e.exp_cnt));
      mon_idx++;
    end
  end

  initial begin
    reset = 1'b0;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0; bus.ex_memread = 1'b0;
    bus.ex_rd = '0; bus.branch_taken_ex = 1'b0; bus.mem_req = 1'b0; bus.dmem_ack = 1'b0;

    // reset and idle
    idle(1'b0, C_NORM, 1'b0, 0);
    idle(1'b1, C_NORM, 1'b0, 0);
    // load-use on rs, then ex_rd=0 (no dependency)
    add(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_LU,   1'b0, 0);
    idle(1'b1, C_NORM, 1'b0, 1);
    add(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_NORM, 1'b0, 1);
    // load-use on rt only counts when id_uses_rt
    add(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_LU,   1'b0, 1);
    add(1'b1, 5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_NORM, 1'b0, 2);
    // branch beats load-use
    add(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, C_BR,   1'b0, 2);
    idle(1'b1, C_NORM, 1'b0, 2);
    // access with ack three cycles late: three freeze cycles, one start
    mem(1'b0, 1'b1, 1'b0, C_FRZ_ST, 1'b0, 2);
    mem(1'b0, 1'b1, 1'b0, C_FRZ,    1'b0, 3);
    mem(1'b0, 1'b1, 1'b0, C_FRZ,    1'b0, 4);
    mem(1'b0, 1'b1, 1'b1, C_NORM,   1'b0, 5);
    idle(1'b1, C_NORM, 1'b0, 5);
    // zero-wait accesses back to back stay in RUN
    mem(1'b0, 1'b1, 1'b1, C_ZW,   1'b0, 5);
    mem(1'b0, 1'b1, 1'b1, C_ZW,   1'b0, 5);
    idle(1'b1, C_NORM, 1'b0, 5);
    // freeze overrides branch; branch applies in the ack cycle
    mem(1'b1, 1'b1, 1'b0, C_FRZ_ST, 1'b0, 5);
    mem(1'b1, 1'b1, 1'b1, C_BR,     1'b0, 6);
    idle(1'b1, C_NORM, 1'b0, 6);
    // timeout: 16 freeze cycles, then sticky error ignoring a late ack
    mem(1'b0, 1'b1, 1'b0, C_FRZ_ST, 1'b0, 6);
    for (int i = 1; i <= 15; i++) mem(1'b0, 1'b1, 1'b0, C_FRZ, 1'b0, 6 + i);
    mem(1'b0, 1'b0, 1'b1, C_FRZ, 1'b1, 22);
    mem(1'b1, 1'b0, 1'b0, C_FRZ, 1'b1, 23);
    // async reset clears the error
    idle(1'b0, C_NORM, 1'b0, 0);
    idle(1'b1, C_NORM, 1'b0, 0);
    // reset mid-access abandons it without re-issuing a start
    mem(1'b0, 1'b1, 1'b0, C_FRZ_ST, 1'b0, 0);
    idle(1'b0, C_NORM, 1'b0, 0);
    idle(1'b1, C_NORM, 1'b0, 0);
    mem(1'b0, 1'b1, 1'b1, C_ZW, 1'b0, 0);

    while (vec_q.size() > 0) begin
      vec_t v;
      v = vec_q.pop_front();
      @(posedge clk);
      #1;
      reset               = v.rst_n;
      bus.id_rs           = v.rs;
      bus.id_rt           = v.rt;
      bus.id_uses_rt      = v.uses_rt;
      bus.ex_memread      = v.memread;
      bus.ex_rd           = v.rd;
      bus.branch_taken_ex = v.br;
      bus.mem_req         = v.mreq;
      bus.dmem_ack        = v.ack;
      exp_q.push_back(v);
    end

    begin
      int budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        errors++;
        $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS-32 pipeline. Drives the enable and flush/bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Resolves three hazard sources in fixed priority:
- data-memory wait states (freeze the pipeline)
- taken branch resolved in EX (flush the wrong path)
- load-use dependency (one-cycle stall)

Parameters:
MEM_TIMEOUT, 15, max MEM_WAIT cycles without dmem_ack before ERROR (1..255)
CNT_W, 16, width of saturating stall-cycle performance counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
id_rs  input  5  rs field of instruction in ID
id_rt  input  5  rt field of instruction in ID
id_uses_rt  input  1  ID instruction reads rt
ex_memread  input  1  instruction in EX is a load
ex_rd  input  5  destination register of instruction in EX
branch_taken_ex  input  1  branch in EX resolved taken
mem_req  input  1  instruction in MEM accesses data memory
dmem_ack  input  1  data memory completes access this cycle
pc_en  output  1  PC update enable
if_id_en  output  1  IF/ID load enable
if_id_flush  output  1  IF/ID clear to NOP
id_ex_en  output  1  ID/EX load enable
id_ex_flush  output  1  ID/EX clear (control bits zero)
ex_mem_en  output  1  EX/MEM load enable
mem_wb_bubble  output  1  MEM/WB loads with regwrite/MemtoReg forced 0
dmem_start  output  1  one-cycle access start strobe to data memory
mem_timeout_err  output  1  sticky timeout error flag
stall_count  output  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
Registered state:
- FSM state (RUN, MEM_WAIT, ERROR), wait_cnt[7:0], mem_timeout_err, stall_count.
- All other outputs are combinational from state and inputs.

Reset (reset=0, async):
- state=RUN, wait_cnt=0, mem_timeout_err=0, stall_count=0.
- With all inputs at 0, outputs are: pc_en=if_id_en=id_ex_en=ex_mem_en=1, all flush/bubble/start outputs=0.

freeze (asserted when a data-memory access is unfinished):
- Condition: (RUN and mem_req and !dmem_ack) or MEM_WAIT-without-ack or ERROR.
- Effect: pc_en=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_bubble=1, all flushes=0.
- Freeze overrides branch flush and load-use stall.

RUN state:
- dmem_start=1 whenever mem_req=1.
- mem_req and dmem_ack in the same cycle: zero-wait access, no freeze, stay in RUN.
- mem_req and !dmem_ack: freeze, go to MEM_WAIT, wait_cnt<=1.
- Otherwise, if branch_taken_ex: if_id_flush=1, id_ex_flush=1, all enables=1.
- Otherwise, on load-use: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, id_ex_en=1.
  - Load-use condition: ex_memread and ex_rd!=0 and (ex_rd==id_rs or (id_uses_rt and ex_rd==id_rt)).
- branch_taken_ex and load-use in the same cycle: branch wins, pc_en=1, no stall.

MEM_WAIT state:
- dmem_start=0.
- dmem_ack=1: no freeze this cycle, so EX/MEM and MEM/WB advance normally. Go to RUN and clear wait_cnt. Branch and load-use logic apply in this cycle as in RUN.
- dmem_ack=0 and wait_cnt==MEM_TIMEOUT: go to ERROR, set mem_timeout_err.
- Otherwise: wait_cnt++ and freeze held.

ERROR state:
- Permanent freeze; mem_timeout_err=1.
- Only reset exits this state; dmem_ack is ignored.

stall_count:
- Increments on every clock with pc_en=0, including during ERROR.
- Saturates at 2^CNT_W-1.

Reset mid-access: the access is abandoned immediately, with no dmem_start re-issue until a new mem_req is seen in RUN.

Test Plan:
- Reset, then idle inputs -> pc_en=if_id_en=id_ex_en=ex_mem_en=1, flushes=0, stall_count=0.
- ex_memread=1, ex_rd=5, id_rs=5, one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1, stall_count=1. Repeat with ex_rd=0 -> no stall.
- branch_taken_ex=1 together with load-use on rt (id_uses_rt=1) -> if_id_flush=id_ex_flush=1, pc_en=1, stall_count unchanged.
- mem_req=1 with dmem_ack delayed 3 cycles -> dmem_start pulses once. Freeze and mem_wb_bubble=1 last 3 cycles, then release in the ack cycle. stall_count=3.
- mem_req=1 with dmem_ack tied 1 -> no freeze, state remains RUN.
- mem_req=1 with no ack, MEM_TIMEOUT=15 -> mem_timeout_err rises after 16 freeze cycles and stays set after a late ack. Async reset clears it and returns all enables to 1.
